// File: rtl/result_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : result_fifo
//  Brief    : Single-clock result FIFO. Buffers WIDTH-bit result words from
//             the compute datapath until the readout logic pops them. The
//             popped word is held in an output register; only `empty` is
//             exported, and pushes into a full FIFO are silently dropped.
//  Revision : 1.0 - initial release
// ============================================================================
module result_fifo #(
  parameter int DEPTH = 1352,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wenable,
  input  logic             renable,
  input  logic [WIDTH-1:0] result_in,
  output logic             empty,
  output logic [WIDTH-1:0] result_out
);

  // A one-entry FIFO still needs a 1-bit pointer so the vectors stay legal.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] result_out_q, result_out_d;

  logic full;
  logic push_ok;
  logic pop_ok;

  // Qualify push and pop independently against the pre-edge occupancy.
  always_comb begin
    full    = (count_q == FULL_CNT);
    push_ok = wenable & ~full;
    pop_ok  = renable & (count_q != '0);
  end

  // Next-state for pointers, occupancy and the held output word.
  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    result_out_d = result_out_q;

    if (push_ok) begin
      wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PTR_ONE;
    end

    if (pop_ok) begin
      rptr_d       = (rptr_q == LAST_PTR) ? '0 : rptr_q + PTR_ONE;
      result_out_d = mem[rptr_q];
    end

    // A simultaneous accepted push and pop leaves the occupancy unchanged.
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset discards contents by clearing pointers/count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      result_out_q <= '0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      result_out_q <= result_out_d;
    end
  end

  // Storage array: no reset so it can map onto RAM; stale data is unreachable.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      mem[wptr_q] <= result_in;
    end
  end

  assign empty      = (count_q == '0);
  assign result_out = result_out_q;

endmodule
`default_nettype wire

// File: tb/tb_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_result_fifo
//  Brief    : Self-checking bench for result_fifo. A queue-based reference
//             model predicts result_out/empty for every driven cycle; a
//             separate monitor pops those predictions and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_result_fifo;

  localparam int DEPTH = 1352;
  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             wenable;
  logic             renable;
  logic [WIDTH-1:0] result_in;
  logic             empty;
  logic [WIDTH-1:0] result_out;

  result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .wenable    (wenable),
    .renable    (renable),
    .result_in  (result_in),
    .empty      (empty),
    .result_out (result_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] exp_out;
    logic             exp_empty;
  } exp_t;

  exp_t             sb[$];      // predictions waiting for the monitor
  logic [WIDTH-1:0] model_q[$]; // reference FIFO contents
  logic [WIDTH-1:0] model_last;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: after every rising edge, compare against the oldest prediction.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("result_out", result_out, e.exp_out);
      chk("empty", {{(WIDTH-1){1'b0}}, empty}, {{(WIDTH-1){1'b0}}, e.exp_empty});
    end
  end

  // Drive one clock cycle and predict its outcome from the FIFO rules.
  task automatic cycle(input logic w, input logic r, input logic [WIDTH-1:0] d);
    bit   push_ok, pop_ok;
    exp_t e;
    @(negedge clk);
    wenable   = w;
    renable   = r;
    result_in = d;
    push_ok = w && (model_q.size() < DEPTH);
    pop_ok  = r && (model_q.size() > 0);
    if (pop_ok)  model_last = model_q.pop_front();
    if (push_ok) model_q.push_back(d);
    e.exp_out   = model_last;
    e.exp_empty = (model_q.size() == 0);
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Asynchronous reset applied between edges; effect must be immediate.
  task automatic do_reset();
    @(negedge clk);
    wenable = 1'b0;
    renable = 1'b0;
    rst     = 1'b1;
    #1;
    model_q.delete();
    model_last = '0;
    chk("reset empty", {{(WIDTH-1){1'b0}}, empty}, 16'd1);
    chk("reset result_out", result_out, 16'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    wenable    = 1'b0;
    renable    = 1'b0;
    result_in  = '0;
    model_last = '0;
    #23;
    chk("por empty", {{(WIDTH-1){1'b0}}, empty}, 16'd1);
    chk("por result_out", result_out, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset/idle: pops on an empty FIFO are ignored.
    cycle(0, 1, 16'd0);
    cycle(0, 1, 16'd0);

    // Gapped writes, back-to-back reads.
    cycle(1, 0, 16'd68);
    cycle(1, 0, 16'd2021);
    for (int i = 0; i < 3; i++) cycle(0, 0, 16'd0);
    cycle(1, 0, 16'd984);
    for (int i = 0; i < 3; i++) cycle(0, 1, 16'd0);

    // Pulsed reads with a hold cycle in between.
    do_reset();
    cycle(1, 0, 16'd68);
    cycle(1, 0, 16'd2021);
    cycle(1, 0, 16'd984);
    cycle(0, 1, 16'd0);
    cycle(0, 0, 16'd0);
    cycle(0, 1, 16'd0);
    cycle(0, 1, 16'd0);
    cycle(0, 0, 16'd0);

    // Full / overflow: extra pushes of 2000 must be dropped.
    for (int i = 1; i <= DEPTH; i++) cycle(1, 0, WIDTH'(i));
    for (int i = 0; i < 4; i++) cycle(1, 0, 16'd2000);
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 16'd0);

    // Wrap-around: second full pass straight after the first.
    for (int i = 1; i <= DEPTH; i++) cycle(1, 0, WIDTH'(i));
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 16'd0);

    // Simultaneous push+pop while full: pop proceeds, push dropped.
    for (int i = 1; i <= DEPTH; i++) cycle(1, 0, WIDTH'(i + 100));
    cycle(1, 1, 16'd7777);
    cycle(1, 0, 16'd4242);   // refills the single freed slot
    cycle(1, 0, 16'd5555);   // full again, dropped
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 16'd0);

    // Simultaneous push+pop while empty: push stored, output unchanged.
    cycle(1, 1, 16'd321);
    cycle(0, 0, 16'd0);
    cycle(0, 1, 16'd0);

    // Reset mid-operation discards stored data.
    cycle(1, 0, 16'd11);
    cycle(1, 1, 16'd12);
    do_reset();
    cycle(0, 1, 16'd0);
    cycle(1, 0, 16'd99);
    cycle(0, 1, 16'd0);

    // Randomized mix, biased occasionally toward filling or draining.
    for (int i = 0; i < 4000; i++) begin
      int wb;
      wb = (i / 500) % 2 == 0 ? 70 : 30;
      cycle(($urandom_range(0, 99) < wb), ($urandom_range(0, 99) < 100 - wb),
            WIDTH'($urandom));
    end
    for (int i = 0; i < DEPTH + 2; i++) cycle(0, 1, 16'd0);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard drained", WIDTH'(sb.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
